// File: rtl/sensor_avg_bank.sv
// sensor_avg_bank
//   Multi-channel leaky-integrator (exponential) averager. Each channel keeps
//   an accumulator acc ~= avg * 2^k and is updated either from its external
//   trig strobe or from the shared internal periodic tick. Requests are latched
//   per channel and served round-robin, one channel per cycle, through a
//   single arithmetic datapath.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   sample    NUM_CH*DW packed samples, channel c at [c*DW +: DW]
//   trig      per-channel update request (level, sampled every edge)
//   seed      per-channel request to load acc from the sample
//   src_sel   per-channel source: 0 = trig, 1 = internal tick
//   win_log2  NUM_CH*LW packed window exponents k (clamped to MAX_LOG2_WIN)
//   avg       NUM_CH*DW registered per-channel averages
//   avg_vld   per-channel one-cycle pulse following each update
//   overrun   per-channel sticky flag: request arrived while one was pending
//   tick      one-cycle pulse while the internal timer is all-ones
module sensor_avg_bank #(
  parameter  int NUM_CH       = 4,
  parameter  int DW           = 12,
  parameter  int MAX_LOG2_WIN = 5,
  parameter  int FAST_SIM     = 1,
  localparam int LW           = $clog2(MAX_LOG2_WIN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] sample,
  input  logic [NUM_CH-1:0]    trig,
  input  logic [NUM_CH-1:0]    seed,
  input  logic [NUM_CH-1:0]    src_sel,
  input  logic [NUM_CH*LW-1:0] win_log2,
  output logic [NUM_CH*DW-1:0] avg,
  output logic [NUM_CH-1:0]    avg_vld,
  output logic [NUM_CH-1:0]    overrun,
  output logic                 tick
);

  localparam int AW = DW + MAX_LOG2_WIN;
  localparam int TW = (FAST_SIM != 0) ? 16 : 22;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_CH - 1);
  localparam logic [LW-1:0] K_MAX    = LW'(MAX_LOG2_WIN);

  logic [TW-1:0]     timer;
  logic [PW-1:0]     ptr;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] spend;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] hit;

  logic [AW-1:0]     acc   [NUM_CH];
  logic [DW-1:0]     avg_r [NUM_CH];

  logic [DW-1:0]     sel_sample;
  logic [LW-1:0]     sel_k_raw;
  logic [LW-1:0]     sel_k;
  logic [AW-1:0]     sel_acc;
  logic              sel_spend;
  logic [AW-1:0]     sample_ext;
  logic [AW-1:0]     new_acc;

  assign tick = &timer;

  // Request decode and operand selection for the channel under the pointer.
  // hit is one-hot (or zero): the channel serviced at the coming edge.
  always_comb begin
    req        = '0;
    hit        = '0;
    sel_sample = '0;
    sel_k_raw  = '0;
    sel_acc    = '0;
    sel_spend  = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      req[c] = src_sel[c] ? tick : trig[c];
      if (ptr == PW'(c)) begin
        sel_sample = sample[c*DW +: DW];
        sel_k_raw  = win_log2[c*LW +: LW];
        sel_acc    = acc[c];
        sel_spend  = spend[c];
        hit[c]     = pend[c];
      end
    end
  end

  assign sel_k      = (sel_k_raw > K_MAX) ? K_MAX : sel_k_raw;
  assign sample_ext = AW'(sel_sample);
  assign new_acc    = sel_spend ? (sample_ext << sel_k)
                                : (sel_acc - (sel_acc >> sel_k) + sample_ext);

  // Service uses the pending state from before the edge; a request landing on
  // the service edge re-arms pend instead of counting as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      ptr     <= '0;
      pend    <= '0;
      spend   <= '0;
      overrun <= '0;
      avg_vld <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc[c]   <= '0;
        avg_r[c] <= '0;
      end
    end else begin
      timer   <= timer + 1'b1;
      ptr     <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      pend    <= (pend & ~hit) | req | seed;
      spend   <= (spend & ~hit) | seed;
      overrun <= overrun | ((req | seed) & pend & ~hit);
      avg_vld <= hit;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (hit[c]) begin
          acc[c]   <= new_acc;
          avg_r[c] <= DW'(new_acc >> sel_k);
        end
      end
    end
  end

  always_comb begin
    avg = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      avg[c*DW +: DW] = avg_r[c];
    end
  end

endmodule

// File: tb/tb_sensor_avg_bank.sv
// tb_sensor_avg_bank
//   Scoreboard bench for sensor_avg_bank: expected averages are computed by a
//   small leaky-integrator model and queued when a request is driven, then
//   matched against avg whenever avg_vld pulses.
module tb_sensor_avg_bank;

  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int MW  = 5;
  localparam int LW  = 3;
  localparam int AW  = DW + MW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH*DW-1:0]  sample;
  logic [NCH-1:0]     trig;
  logic [NCH-1:0]     seed;
  logic [NCH-1:0]     src_sel;
  logic [NCH*LW-1:0]  win_log2;
  logic [NCH*DW-1:0]  avg;
  logic [NCH-1:0]     avg_vld;
  logic [NCH-1:0]     overrun;
  logic               tick;

  sensor_avg_bank #(
    .NUM_CH(NCH),
    .DW(DW),
    .MAX_LOG2_WIN(MW),
    .FAST_SIM(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample(sample),
    .trig(trig),
    .seed(seed),
    .src_sel(src_sel),
    .win_log2(win_log2),
    .avg(avg),
    .avg_vld(avg_vld),
    .overrun(overrun),
    .tick(tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            ch;
    logic [DW-1:0] val;
    int            req_edge;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] m_acc [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_s(input int ch, input logic [DW-1:0] s);
    sample[ch*DW +: DW] = s;
  endtask

  task automatic set_k(input int ch, input logic [LW-1:0] k);
    win_log2[ch*LW +: LW] = k;
  endtask

  // Model one update of channel ch using the currently driven sample and k.
  task automatic expect_update(input int ch, input bit sd, input int redge);
    logic [LW-1:0] k;
    logic [AW-1:0] ext;
    exp_t          e;
    k = win_log2[ch*LW +: LW];
    if (k > LW'(MW)) k = LW'(MW);
    ext = AW'(sample[ch*DW +: DW]);
    if (sd) m_acc[ch] = ext << k;
    else    m_acc[ch] = m_acc[ch] - (m_acc[ch] >> k) + ext;
    e.ch       = ch;
    e.val      = DW'(m_acc[ch] >> k);
    e.req_edge = redge;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_vld(input int ch, input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avg_vld[ch] && n < maxc);
    if (!avg_vld[ch]) check("vld_timeout", 0, 1);
  endtask

  // One-cycle request on every channel in tm (trig) / sm (seed), then wait.
  task automatic req_mask(input logic [NCH-1:0] tm, input logic [NCH-1:0] sm);
    for (int c = 0; c < NCH; c++)
      if (tm[c] | sm[c]) expect_update(c, sm[c], cyc + 1);
    trig = tm;
    seed = sm;
    @(negedge clk); #1;
    trig = '0;
    seed = '0;
    drain(20);
  endtask

  // Monitor: match every avg_vld pulse against the scoreboard.
  int prev_vld_cyc = -10;
  int prev_ch      = 0;
  always @(negedge clk) begin
    int idx;
    int lat;
    if (avg_vld != '0) begin
      check("vld_onehot", $countones(avg_vld), 1);
      for (int c = 0; c < NCH; c++) begin
        if (avg_vld[c]) begin
          idx = -1;
          foreach (exp_q[i]) if (idx < 0 && exp_q[i].ch == c) idx = i;
          if (idx < 0) begin
            check("unexpected_vld", c + 100, 0);
          end else begin
            check("avg", avg[c*DW +: DW], exp_q[idx].val);
            lat = cyc - exp_q[idx].req_edge;
            check("latency_in_range", (lat >= 1 && lat <= NCH), 1);
            exp_q.delete(idx);
          end
          if (prev_vld_cyc == cyc - 1) check("rr_order", c, (prev_ch + 1) % NCH);
          prev_vld_cyc = cyc;
          prev_ch      = c;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int rel;
    bit found;

    rst      = 1'b1;
    trig     = '0;
    seed     = '0;
    src_sel  = '0;
    sample   = '0;
    win_log2 = '0;
    for (int c = 0; c < NCH; c++) m_acc[c] = '0;

    @(negedge clk); #1;
    check("rst_avg", avg, 0);
    check("rst_vld", avg_vld, 0);
    check("rst_ovr", overrun, 0);
    check("rst_tick", tick, 0);
    rst = 1'b0;

    // Seed then integrate, k=2.
    set_k(0, 3'd2);
    set_s(0, 12'h800);
    req_mask(4'b0000, 4'b0001);
    check("acc0_seed", dut.acc[0], 17'h02000);
    set_s(0, 12'h000);
    req_mask(4'b0001, 4'b0000);
    check("acc0_int1", dut.acc[0], 17'h01800);
    check("avg0_int1", avg[11:0], 12'h600);
    req_mask(4'b0001, 4'b0000);
    check("avg0_int2", avg[11:0], 12'h480);

    // Steady state at full scale, k=5.
    set_k(0, 3'd5);
    set_s(0, 12'hFFF);
    req_mask(4'b0000, 4'b0001);
    for (int i = 0; i < 100; i++) req_mask(4'b0001, 4'b0000);
    check("acc0_steady", dut.acc[0], 17'h1FFE0);
    check("avg0_steady", avg[11:0], 12'hFFF);

    // Seed together with trig gives one seeded update.
    set_k(1, 3'd3);
    set_s(1, 12'h0A5);
    req_mask(4'b0010, 4'b0010);

    // Round robin on all channels; ch1 k=7 exercises the clamp.
    set_k(0, 3'd2);
    set_k(1, 3'd7);
    set_k(2, 3'd0);
    set_k(3, 3'd3);
    set_s(0, 12'h100);
    set_s(1, 12'h7FF);
    set_s(2, 12'h333);
    set_s(3, 12'hABC);
    req_mask(4'b0000, 4'b1111);
    set_s(0, 12'h900);
    set_s(1, 12'h001);
    set_s(2, 12'hC0C);
    set_s(3, 12'h010);
    req_mask(4'b1111, 4'b0000);
    check("ovr_after_rr", overrun, 0);

    // Request coinciding with ch2's service edge does not set overrun.
    set_k(2, 3'd1);
    set_s(2, 12'h123);
    req_mask(4'b0000, 4'b0100);
    expect_update(2, 1'b0, cyc + 1);
    trig[2] = 1'b1;
    @(negedge clk); #1;
    trig[2] = 1'b0;
    wait_vld(2, 10); #1;
    expect_update(2, 1'b0, cyc + 1);
    trig[2] = 1'b1;
    @(negedge clk); #1;
    trig[2] = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    expect_update(2, 1'b0, cyc + 1);
    trig[2] = 1'b1;
    @(negedge clk); #1;
    trig[2] = 1'b0;
    drain(20);
    check("ovr_coincide", overrun, 0);

    // trig ch2 held for 10 edges: three merged services, overrun set.
    t0 = cyc;
    expect_update(2, 1'b0, t0 + 1);
    expect_update(2, 1'b0, t0 + 5);
    expect_update(2, 1'b0, t0 + 9);
    trig[2] = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    trig[2] = 1'b0;
    drain(20);
    check("ovr_held", overrun, 4'b0100);
    repeat (8) @(negedge clk);
    #1;
    check("ovr_sticky", overrun, 4'b0100);

    // Reset while ch1/ch3 are pending.
    trig = 4'b1010;
    @(posedge clk); #1;
    rst  = 1'b1;
    trig = '0;
    #1;
    check("midrst_avg", avg, 0);
    check("midrst_vld", avg_vld, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_tick", tick, 0);
    exp_q.delete();
    for (int c = 0; c < NCH; c++) m_acc[c] = '0;

    // Internal tick drives ch0 and ch2 only.
    src_sel = 4'b0101;
    set_k(0, 3'd2);
    set_s(0, 12'h400);
    set_k(2, 3'd1);
    set_s(2, 12'h0F0);
    @(negedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_avg", avg, 0);

    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      if (tick) found = 1'b1;
    end
    if (!found) begin
      check("tick_timeout", 0, 1);
    end else begin
      check("tick_first", cyc - rel, 65535);
      #1;
      expect_update(0, 1'b0, cyc + 1);
      expect_update(2, 1'b0, cyc + 1);
      @(negedge clk);
      check("tick_pulse", tick, 0);
      #1;
      drain(10);
    end
    repeat (10) @(negedge clk);
    #1;
    check("tick_ch0", avg[0*DW +: DW], 12'h100);
    check("tick_ch2", avg[2*DW +: DW], 12'h078);
    check("tick_ch1", avg[1*DW +: DW], 0);
    check("tick_ch3", avg[3*DW +: DW], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_avg_bank.md
# sensor_avg_bank

Parametrised, multi-channel successor to the single-purpose current/torque averagers in sensor conditioning. It applies a leaky-integrator (exponential) average to each of NUM_CH sample channels. Each channel has its own runtime window and its own update source: an external event strobe or the internal periodic tick. Requests are queued per channel and served by a round-robin sequencer, one channel per cycle, so there is a single arithmetic datapath; overrun is flagged. It sits between the A2D/cadence front end and the drive/telemetry consumers.

## Interface
- NUM_CH, default 4: number of channels (1..8).
- DW, default 12: sample and average width.
- MAX_LOG2_WIN, default 5: largest window exponent k; accumulator width AW = DW+MAX_LOG2_WIN.
- FAST_SIM, default 1: internal tick period is 2^16 cycles when 1, 2^22 cycles when 0.
- LW (local, not overridable): $clog2(MAX_LOG2_WIN+1).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample  in  NUM_CH*DW  packed samples; channel c is at [c*DW +: DW].
- trig  in  NUM_CH  per-channel update request (level, sampled every edge).
- seed  in  NUM_CH  per-channel seed request: load the accumulator from the sample instead of integrating.
- src_sel  in  NUM_CH  0: trig is the update source; 1: the internal tick is the update source.
- win_log2  in  NUM_CH*LW  per-channel k; values above MAX_LOG2_WIN clamp to MAX_LOG2_WIN.
- avg  out  NUM_CH*DW  registered per-channel average.
- avg_vld  out  NUM_CH  one-cycle pulse per channel update.
- overrun  out  NUM_CH  sticky flag: a request arrived while one was already pending.
- tick  out  1  internal timer full, one-cycle pulse.

## Operation
- **Timer:** free-running counter of 16 bits (FAST_SIM=1) or 22 bits (FAST_SIM=0). tick=1 when all bits are 1; the counter wraps.
- **Request per channel c:** req_c = src_sel[c] ? tick : trig[c]. seed[c] also counts as a request.
- **Request latching:** pend[c] is set on req_c or seed[c]; spend[c] (seed pending) is set on seed[c].
- **Sequencer:** pointer ptr advances every cycle, 0..NUM_CH-1, wrapping to 0. At each edge, if pend[ptr]=1, channel ptr is serviced:
  - spend=1: acc <= sample << k.
  - spend=0: acc <= acc - (acc >> k) + sample.
  - avg[ptr] <= new_acc >> k, truncated to DW.
  - pend[ptr] and spend[ptr] clear.
  - avg_vld[ptr] is high for the next cycle.
- **Width rule:** with k <= MAX_LOG2_WIN the accumulator cannot exceed 2^AW-1. No saturation logic is required. k is read at service time.
- **Window change:** a change of k takes effect at the next service. The accumulator is not rescaled; use seed to restart cleanly.
- **Simultaneous events:**
  - Request at the same edge as service of that channel: the service uses the old pending state; pend stays set for a new service; no overrun.
  - Request while pend=1 and that channel is not being serviced: overrun[c] is set. The requests merge into one update.
  - seed together with trig: a single seeded update.
- **overrun** stays set until reset.

## Timing
- **Reset values:** avg=0, avg_vld=0, overrun=0, tick=0, all accumulators, pend, spend, ptr and timer = 0.
- **Reset mid-operation:** pending requests are discarded; there is no partial update.
- **Update latency:** a request sampled at edge E is serviced at the first edge after E where ptr=c. That is 1..NUM_CH cycles. avg is updated at the service edge; avg_vld is high in the cycle following it.
- **Throughput:** one channel per cycle. Each channel can be serviced at most once per NUM_CH cycles.
- **tick:** asserted in the cycle the timer is all-ones. It is first asserted 2^16-1 cycles after reset release (FAST_SIM=1).
- **Reset release:** async assert; the first update is possible on the second edge after release.

## Test plan
- **Seed then integrate:** NUM_CH=4, DW=12, k=2, ch0 seed with sample 0x800 -> avg0=0x800, avg_vld0 pulses once. Then trig with sample 0x000 -> avg0=0x600 (acc 0x1800). Repeat -> avg0=0x480.
- **Steady state:** k=5, seed 0xFFF, then 100 trigs with 0xFFF -> avg stays 0xFFF, acc=0x1FFE0, no overflow.
- **Round-robin latency:** trig on all 4 channels in one cycle -> four avg_vld pulses on consecutive cycles, each within 4 cycles of the request, in ptr order; overrun=0.
- **Overrun:** trig ch2 held high 10 cycles -> ch2 serviced every 4 cycles; overrun2=1 and stays 1 until rst. A request coinciding with ch2's service edge alone does not set it.
- **Internal tick:** FAST_SIM=1, src_sel=4'b0101, trig idle -> ch0 and ch2 update once per 65536 cycles, following each tick pulse; ch1 and ch3 never update.
- **Reset mid-operation:** assert rst while ch1/ch3 are pending -> all outputs 0 immediately. After release with no requests -> no avg_vld pulses.
